// File: rtl/nios2f_cpu_mul_pkg.sv
// Shared definitions for the Nios II/f multiply sequencer and its result combiner.
package nios2f_cpu_mul_pkg;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULXUU = 2'b01,
        MUL_OP_MULXSU = 2'b10,
        MUL_OP_MULXSS = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CAP1 = 2'b01,
        ST_CAP2 = 2'b10,
        ST_OUT  = 2'b11
    } mul_state_e;

    // Upper half of a word, zero-extended, as fed to the cell for the ahi*bhi pass.
    function automatic logic [WORD_W-1:0] hi_half(input logic [WORD_W-1:0] w);
        return {{HALF_W{1'b0}}, w[WORD_W-1:HALF_W]};
    endfunction

endpackage

// File: rtl/nios2f_cpu_mul_combine.sv
// Folds the cell's partial products into the low word and the (sign-corrected) high word.
module nios2f_cpu_mul_combine
    import nios2f_cpu_mul_pkg::*;
(
    input  logic [WORD_W-1:0] ll,
    input  logic [WORD_W:0]   mid,
    input  logic [WORD_W-1:0] hh,
    input  mul_op_e           op,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] lo,
    output logic [WORD_W-1:0] hi
);

    logic [WORD_W:0]   lo_sum;
    logic              carry;
    logic [WORD_W-1:0] hu;
    logic [WORD_W-1:0] corr_a;
    logic [WORD_W-1:0] corr_b;

    always_comb begin
        lo_sum = {1'b0, ll} + {1'b0, mid[HALF_W-1:0], {HALF_W{1'b0}}};
        lo     = lo_sum[WORD_W-1:0];
        carry  = lo_sum[WORD_W];
        hu     = hh
               + {{(WORD_W-HALF_W-1){1'b0}}, mid[WORD_W:HALF_W]}
               + {{(WORD_W-1){1'b0}}, carry};

        // Treating a negative operand as unsigned adds (other operand << 32); remove it.
        corr_a = a[WORD_W-1] ? b : '0;
        corr_b = b[WORD_W-1] ? a : '0;

        case (op)
            MUL_OP_MULXSU: hi = hu - corr_a;
            MUL_OP_MULXSS: hi = hu - corr_a - corr_b;
            default:       hi = hu;
        endcase
    end

endmodule

// File: rtl/nios2f_cpu_mul_seq.sv
// Sequencer around the three-product 16x16 multiplier cell: one pass for MUL,
// a second ahi*bhi pass for the MULX* high-word ops.
module nios2f_cpu_mul_seq
    import nios2f_cpu_mul_pkg::*;
#(
    parameter bit MULX_EN = 1'b1
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WORD_W-1:0] src_a,
    input  logic [WORD_W-1:0] src_b,
    input  logic              kill,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result,
    output logic [WORD_W-1:0] cell_src1,
    output logic [WORD_W-1:0] cell_src2,
    output logic              cell_en,
    input  logic [WORD_W-1:0] cell_p1,
    input  logic [WORD_W-1:0] cell_p2,
    input  logic [WORD_W-1:0] cell_p3
);

    mul_state_e        state_reg, state_next;
    logic [WORD_W-1:0] a_reg, b_reg;
    mul_op_e           op_reg;
    logic [WORD_W-1:0] ll_reg, hh_reg, result_reg;
    logic [WORD_W:0]   mid_reg;
    logic              done_reg;

    logic              accept;
    logic              cap1;
    logic              cap2;
    logic              finish;
    logic [WORD_W:0]   mid_sum;
    logic [WORD_W-1:0] comb_ll, comb_hh;
    logic [WORD_W:0]   comb_mid;
    logic [WORD_W-1:0] lo_word, hi_word;
    logic [WORD_W-1:0] result_next;

    assign mid_sum = {1'b0, cell_p2} + {1'b0, cell_p3};

    always_comb begin
        state_next = state_reg;
        cell_src1  = '0;
        cell_src2  = '0;
        cell_en    = 1'b0;
        accept     = 1'b0;
        cap1       = 1'b0;
        cap2       = 1'b0;
        finish     = 1'b0;

        case (state_reg)
            // OUT behaves like IDLE for the request path so a start in the done cycle is taken.
            ST_IDLE, ST_OUT: begin
                cell_src1  = src_a;
                cell_src2  = src_b;
                state_next = ST_IDLE;
                if (!kill && start) begin
                    cell_en    = 1'b1;
                    accept     = 1'b1;
                    state_next = ST_CAP1;
                end
            end
            ST_CAP1: begin
                if (kill) begin
                    state_next = ST_IDLE;
                end else begin
                    cap1 = 1'b1;
                    if (op_reg == MUL_OP_MUL || !MULX_EN) begin
                        finish     = 1'b1;
                        state_next = ST_OUT;
                    end else begin
                        cell_src1  = hi_half(a_reg);
                        cell_src2  = hi_half(b_reg);
                        cell_en    = 1'b1;
                        state_next = ST_CAP2;
                    end
                end
            end
            ST_CAP2: begin
                if (kill) begin
                    state_next = ST_IDLE;
                end else begin
                    cap2       = 1'b1;
                    finish     = 1'b1;
                    state_next = ST_OUT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Products are folded in the cycle they arrive so done lands in the OUT cycle itself.
    always_comb begin
        comb_ll  = (state_reg == ST_CAP1) ? cell_p1 : ll_reg;
        comb_mid = (state_reg == ST_CAP1) ? mid_sum : mid_reg;
        comb_hh  = (state_reg == ST_CAP2) ? cell_p1 : hh_reg;
    end

    nios2f_cpu_mul_combine u_combine (
        .ll  (comb_ll),
        .mid (comb_mid),
        .hh  (comb_hh),
        .op  (op_reg),
        .a   (a_reg),
        .b   (b_reg),
        .lo  (lo_word),
        .hi  (hi_word)
    );

    assign result_next = (op_reg == MUL_OP_MUL) ? lo_word : hi_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= MUL_OP_MUL;
            ll_reg     <= '0;
            mid_reg    <= '0;
            hh_reg     <= '0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= finish;
            if (accept) begin
                a_reg  <= src_a;
                b_reg  <= src_b;
                op_reg <= MULX_EN ? mul_op_e'(op) : MUL_OP_MUL;
            end
            if (cap1) begin
                ll_reg  <= cell_p1;
                mid_reg <= mid_sum;
            end
            if (cap2) begin
                hh_reg <= cell_p1;
            end
            if (finish) begin
                result_reg <= result_next;
            end
        end
    end

    assign busy   = (state_reg != ST_IDLE);
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_nios2f_cpu_mul_seq.sv
// Scoreboard bench for the multiply sequencer with a behavioural model of the multiplier cell.
module tb_nios2f_cpu_mul_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy, done, cell_en;
    logic [31:0] result, cell_src1, cell_src2;
    logic [31:0] cell_p1 = '0;
    logic [31:0] cell_p2 = '0;
    logic [31:0] cell_p3 = '0;

    nios2f_cpu_mul_seq #(.MULX_EN(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .kill      (kill),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cell_src1 (cell_src1),
        .cell_src2 (cell_src2),
        .cell_en   (cell_en),
        .cell_p1   (cell_p1),
        .cell_p2   (cell_p2),
        .cell_p3   (cell_p3)
    );

    always #5 clk = ~clk;

    // Multiplier cell: registered lo*lo, alo*bhi, ahi*blo.
    always @(posedge clk) begin
        if (cell_en) begin
            cell_p1 <= 32'(cell_src1[15:0]) * 32'(cell_src2[15:0]);
            cell_p2 <= 32'(cell_src1[15:0]) * 32'(cell_src2[31:16]);
            cell_p3 <= 32'(cell_src1[31:16]) * 32'(cell_src2[15:0]);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, required %08h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: cycle %0d result %08h, required no done", cyc, result);
            end else begin
                mon_e = sbq.pop_front();
                $display("txn %s: result=%08h cycle=%0d", mon_e.nm, result, cyc);
                check({mon_e.nm, " result"}, result, mon_e.res);
                check({mon_e.nm, " latency"}, cyc, mon_e.due);
            end
        end else if (sbq.size() != 0 && cyc > sbq[0].due) begin
            n_total++;
            $display("FAIL %s missing_done: no done by cycle %0d, required at %0d", sbq[0].nm, cyc, sbq[0].due);
            void'(sbq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string nm, input bit push);
        exp_t e;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        if (push) begin
            e.res = exp;
            e.due = cyc + ((o == 2'b00) ? 2 : 3);
            e.nm  = nm;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
        if (sbq.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d results outstanding, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        drive(o, a, b, exp, nm, 1'b1);
        tick();
        start = 1'b0;
        drain();
    endtask

    function automatic logic [31:0] golden(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (o == 2'b10 || o == 2'b11) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (o == 2'b11) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset result", result, 32'h0);
        check("reset cell_en", {31'b0, cell_en}, 32'd0);
        check("reset cell_src1", cell_src1, 32'h0);
        check("reset cell_src2", cell_src2, 32'h0);

        // MUL: single pass, cell_en only in the accept cycle
        drive(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, "mul_basic", 1'b1);
        @(negedge clk);
        check("mul T cell_en", {31'b0, cell_en}, 32'd1);
        check("mul T cell_src1", cell_src1, 32'h0001_0003);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("mul T+1 cell_en", {31'b0, cell_en}, 32'd0);
        check("mul T+1 busy", {31'b0, busy}, 32'd1);
        drain();

        // MULXUU: second pass issues the high halves
        drive(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulxuu_max", 1'b1);
        tick();
        start = 1'b0;
        @(negedge clk);
        check("mulxuu T+1 cell_en", {31'b0, cell_en}, 32'd1);
        check("mulxuu T+1 cell_src1", cell_src1, 32'h0000_FFFF);
        check("mulxuu T+1 cell_src2", cell_src2, 32'h0000_FFFF);
        drain();

        run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "mulxss_neg1x2");
        run_op(2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, "mulxsu_min");
        run_op(2'b01, 32'h0000_FFFF, 32'hFFFF_0001, 32'h0000_FFFE, "mulxuu_carry");

        // Back-to-back: second start in the done cycle of the first
        drive(2'b00, 32'd3, 32'd4, 32'd12, "b2b_first", 1'b1);
        tick();
        start = 1'b0;
        tick();
        drive(2'b00, 32'd5, 32'd6, 32'd30, "b2b_second", 1'b1);
        tick();
        start = 1'b0;
        drain();

        // start during CAP1 is ignored; exactly one done
        drive(2'b01, 32'h0003_0000, 32'h0005_0000, 32'h0000_000F, "start_in_cap1", 1'b1);
        tick();
        drive(2'b00, 32'd1, 32'd1, 32'd1, "ignored", 1'b0);
        tick();
        start = 1'b0;
        drain();
        repeat (3) tick();

        // kill in CAP2: no done, result unchanged
        drive(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, "killed_cap2", 1'b0);
        tick();
        start = 1'b0;
        tick();
        kill = 1'b1;
        @(negedge clk);
        check("kill cap2 busy", {31'b0, busy}, 32'd1);
        tick();
        kill = 1'b0;
        @(negedge clk);
        check("kill cap2 busy after", {31'b0, busy}, 32'd0);
        repeat (3) tick();
        check("kill cap2 result held", result, 32'h0000_000F);
        run_op(2'b00, 32'd2, 32'd3, 32'd6, "mul_after_kill");

        // kill in CAP1 of a MULX suppresses the second-pass enable
        drive(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0, "killed_cap1", 1'b0);
        tick();
        start = 1'b0;
        kill = 1'b1;
        @(negedge clk);
        check("kill cap1 cell_en", {31'b0, cell_en}, 32'd0);
        tick();
        kill = 1'b0;
        repeat (3) tick();
        check("kill cap1 result held", result, 32'd6);
        check("kill cap1 busy", {31'b0, busy}, 32'd0);

        // asynchronous reset in CAP1
        drive(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0, "reset_mid", 1'b0);
        tick();
        start = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async reset busy", {31'b0, busy}, 32'd0);
        check("async reset done", {31'b0, done}, 32'd0);
        check("async reset result", result, 32'h0);
        check("async reset cell_en", {31'b0, cell_en}, 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        run_op(2'b00, 32'd7, 32'd6, 32'h0000_002A, "mul_after_reset");

        // random operands against a 64-bit golden product
        for (int o = 0; o < 4; o++) begin
            for (int n = 0; n < 1000; n++) begin
                logic [31:0] ra, rb;
                ra = $urandom;
                rb = $urandom;
                run_op(2'(o), ra, rb, golden(2'(o), ra, rb), $sformatf("rand_op%0d_%0d", o, n));
            end
        end

        drain();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
